// File: rtl/vc_dest_arbiter_pkg.sv
// Purpose: shared parameters, FSM encoding and destination decode for the VC-to-destination arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vc_dest_arbiter_pkg;

    localparam int unsigned WORD_W    = 6;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned BURST_W   = $clog2(MAX_BURST + 1);
    // The top bit of each word names its destination FIFO (0 -> D0, 1 -> D1).
    localparam int unsigned DEST_BIT  = WORD_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } state_t;

    function automatic logic dest_of(input logic [WORD_W-1:0] word);
        return word[DEST_BIT];
    endfunction

endpackage

// File: rtl/vc_dest_arbiter_if.sv
// Purpose: bundles the VC FIFO heads, destination thresholds and arbiter outputs.
// Latency: n/a (wires only).
// Backpressure: d*_almost_full from the destinations; pops toward the VC FIFOs.
// Ports: slave = arbiter side, master = FIFO/link side driving the arbiter.
interface vc_dest_arbiter_if;
    import vc_dest_arbiter_pkg::*;

    logic              active;
    logic              vc0_empty;
    logic [WORD_W-1:0] vc0_data;
    logic              vc1_empty;
    logic [WORD_W-1:0] vc1_data;
    logic              d0_almost_full;
    logic              d1_almost_full;
    logic              pop_vc0;
    logic              pop_vc1;
    logic              push_d0;
    logic              push_d1;
    logic [WORD_W-1:0] data_out;
    logic              stall_out;
    logic              idle_out;
    logic [CNT_W-1:0]  sent_d0;
    logic [CNT_W-1:0]  sent_d1;

    modport slave (
        input  active, vc0_empty, vc0_data, vc1_empty, vc1_data,
               d0_almost_full, d1_almost_full,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out,
               stall_out, idle_out, sent_d0, sent_d1
    );

    modport master (
        output active, vc0_empty, vc0_data, vc1_empty, vc1_data,
               d0_almost_full, d1_almost_full,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out,
               stall_out, idle_out, sent_d0, sent_d1
    );

endinterface

// File: rtl/vc_dest_arbiter_burst_limiter.sv
// Purpose: counts consecutive VC0 grants taken while VC1 was waiting; flags when VC1 must win.
// Latency: limit_hit reflects grants up to the previous cycle.
// Backpressure: none; pure bookkeeping.
// Ports: i_clk, i_reset, i_grant0, i_grant1, i_e1 in; o_limit_hit out.
module vc_burst_limiter
    import vc_dest_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_grant0,
    input  logic i_grant1,
    input  logic i_e1,
    output logic o_limit_hit
);

    logic [BURST_W-1:0] r_burst_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_burst_cnt <= '0;
        end else if (i_grant1 || !i_e1) begin
            // VC1 got served or is not waiting: the starvation window restarts.
            r_burst_cnt <= '0;
        end else if (i_grant0 && (r_burst_cnt != BURST_W'(MAX_BURST))) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    assign o_limit_hit = (r_burst_cnt == BURST_W'(MAX_BURST));

endmodule

// File: rtl/vc_dest_arbiter.sv
// Purpose: moves words from VC0/VC1 into D0/D1, strict VC0 priority with a VC1 anti-starvation burst limit.
// Latency: combinational pop in cycle N, registered push + data_out in cycle N+1; 1 word/cycle.
// Backpressure: a VC whose head targets an almost-full destination is ineligible; nothing eligible -> STALL.
// Ports: i_clk, i_reset (sync, active-high); io_arb (slave modport) carries all handshake/data signals.
module vc_dest_arbiter
    import vc_dest_arbiter_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    vc_dest_arbiter_if.slave   io_arb
);

    state_t            r_state;
    state_t            w_next;
    logic              w_af0;
    logic              w_af1;
    logic              w_e0;
    logic              w_e1;
    logic              w_run;
    logic              w_limit_hit;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_any_grant;
    logic [WORD_W-1:0] w_word;
    logic              w_push_d0;
    logic              w_push_d1;

    logic              r_push_d0;
    logic              r_push_d1;
    logic [WORD_W-1:0] r_data;
    logic              r_idle;
    logic              r_stall;
    logic [CNT_W-1:0]  r_sent_d0;
    logic [CNT_W-1:0]  r_sent_d1;

    // Eligibility looks at the threshold of whichever destination the head word targets.
    assign w_af0 = dest_of(io_arb.vc0_data) ? io_arb.d1_almost_full : io_arb.d0_almost_full;
    assign w_af1 = dest_of(io_arb.vc1_data) ? io_arb.d1_almost_full : io_arb.d0_almost_full;
    assign w_e0  = !io_arb.vc0_empty && !w_af0;
    assign w_e1  = !io_arb.vc1_empty && !w_af1;

    assign w_run       = (r_state == ST_RUN) && io_arb.active;
    assign w_grant0    = w_run && w_e0 && (!w_e1 || !w_limit_hit);
    assign w_grant1    = w_run && w_e1 && (!w_e0 || w_limit_hit);
    assign w_any_grant = w_grant0 || w_grant1;
    assign w_word      = w_grant1 ? io_arb.vc1_data : io_arb.vc0_data;
    assign w_push_d0   = w_any_grant && !dest_of(w_word);
    assign w_push_d1   = w_any_grant &&  dest_of(w_word);

    vc_burst_limiter u_burst_limiter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_grant0    (w_grant0),
        .i_grant1    (w_grant1),
        .i_e1        (w_e1),
        .o_limit_hit (w_limit_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (io_arb.active) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!io_arb.active) begin
                    w_next = ST_IDLE;
                end else if (!w_e0 && !w_e1 && (!io_arb.vc0_empty || !io_arb.vc1_empty)) begin
                    w_next = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!io_arb.active) begin
                    w_next = ST_IDLE;
                end else if (w_e0 || w_e1) begin
                    w_next = ST_RUN;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Status flags track the state register exactly, so they load from the next-state value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_push_d0 <= 1'b0;
            r_push_d1 <= 1'b0;
            r_data    <= '0;
            r_idle    <= 1'b1;
            r_stall   <= 1'b0;
            r_sent_d0 <= '0;
            r_sent_d1 <= '0;
        end else begin
            r_push_d0 <= w_push_d0;
            r_push_d1 <= w_push_d1;
            if (w_any_grant) r_data <= w_word;
            r_idle    <= (w_next == ST_IDLE);
            r_stall   <= (w_next == ST_STALL);
            r_sent_d0 <= r_sent_d0 + CNT_W'(w_push_d0);
            r_sent_d1 <= r_sent_d1 + CNT_W'(w_push_d1);
        end
    end

    assign io_arb.pop_vc0   = w_grant0;
    assign io_arb.pop_vc1   = w_grant1;
    assign io_arb.push_d0   = r_push_d0;
    assign io_arb.push_d1   = r_push_d1;
    assign io_arb.data_out  = r_data;
    assign io_arb.idle_out  = r_idle;
    assign io_arb.stall_out = r_stall;
    assign io_arb.sent_d0   = r_sent_d0;
    assign io_arb.sent_d1   = r_sent_d1;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Purpose: directed bench for vc_dest_arbiter with show-ahead VC FIFO models and a push scoreboard.
// Latency: expects push one cycle after pop.
// Backpressure: drives d*_almost_full directly.
module tb_vc_dest_arbiter;
    import vc_dest_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [WORD_W-1:0] q0[$];
    logic [WORD_W-1:0] q1[$];
    logic [WORD_W-1:0] exp_q[$];

    vc_dest_arbiter_if arb_if ();

    vc_dest_arbiter dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_arb  (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Show-ahead FIFO models: a pop seen before the edge removes the head after it.
    initial begin
        logic p0;
        logic p1;
        arb_if.vc0_empty = 1'b1;
        arb_if.vc0_data  = '0;
        arb_if.vc1_empty = 1'b1;
        arb_if.vc1_data  = '0;
        forever begin
            @(negedge clk);
            p0 = arb_if.pop_vc0;
            p1 = arb_if.pop_vc1;
            @(posedge clk);
            #1;
            if (p0 === 1'b1) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL pop_vc0_empty: got pop expected no pop");
                end else void'(q0.pop_front());
            end
            if (p1 === 1'b1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL pop_vc1_empty: got pop expected no pop");
                end else void'(q1.pop_front());
            end
            #1;
            arb_if.vc0_empty = (q0.size() == 0);
            arb_if.vc0_data  = (q0.size() != 0) ? q0[0] : '0;
            arb_if.vc1_empty = (q1.size() == 0);
            arb_if.vc1_data  = (q1.size() != 0) ? q1[0] : '0;
        end
    end

    // Scoreboard monitor: every push must match the next expected word and its destination.
    always @(negedge clk) begin
        if (arb_if.push_d0 === 1'b1 || arb_if.push_d1 === 1'b1) begin
            logic [WORD_W-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected: got d0=%0b d1=%0b data=%0h expected no push",
                         arb_if.push_d0, arb_if.push_d1, arb_if.data_out);
            end else begin
                e = exp_q.pop_front();
                if (arb_if.push_d0 !== !e[WORD_W-1] || arb_if.push_d1 !== e[WORD_W-1] ||
                    arb_if.data_out !== e) begin
                    errors++;
                    $display("FAIL push_word: got d0=%0b d1=%0b data=%0h expected data=%0h",
                             arb_if.push_d0, arb_if.push_d1, arb_if.data_out, e);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        arb_if.active = 1'b0;
        arb_if.d0_almost_full = 1'b0;
        arb_if.d1_almost_full = 1'b0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_idle", arb_if.idle_out, 1);
        chk("rst_stall", arb_if.stall_out, 0);
        chk("rst_push_d0", arb_if.push_d0, 0);
        chk("rst_push_d1", arb_if.push_d1, 0);
        chk("rst_data", arb_if.data_out, 0);
        chk("rst_sent_d0", arb_if.sent_d0, 0);
        chk("rst_sent_d1", arb_if.sent_d1, 0);
        chk("rst_pop_vc0", arb_if.pop_vc0, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", arb_if.idle_out, 1);
        tick();
        arb_if.active = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("active_idle_low", arb_if.idle_out, 0);

        // Single stream: three VC0 words to D0
        tick();
        for (int i = 1; i <= 3; i++) begin
            q0.push_back(6'(i));
            exp_q.push_back(6'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stream_pop_vc0", arb_if.pop_vc0, 1);
        end
        @(negedge clk);
        chk("stream_pop_done", arb_if.pop_vc0, 0);
        chk("stream_sent_d0", arb_if.sent_d0, 3);

        // Burst limit: 8 VC0 words vs 3 VC1 words, all to D0
        tick();
        arb_if.active = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) q0.push_back(6'h10 + 6'(i));
        for (int i = 0; i < 3; i++) q1.push_back(6'h08 + 6'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(6'h10 + 6'(i));
        exp_q.push_back(6'h08);
        for (int i = 4; i < 8; i++) exp_q.push_back(6'h10 + 6'(i));
        exp_q.push_back(6'h09);
        exp_q.push_back(6'h0A);
        arb_if.active = 1'b1;
        repeat (14) tick();
        @(negedge clk);
        chk("burst_sent_d0", arb_if.sent_d0, 14);
        chk("burst_idle", arb_if.idle_out, 0);

        // Back-pressure: VC0 head to D1 while D1 almost full
        tick();
        arb_if.d1_almost_full = 1'b1;
        q0.push_back(6'h21);
        exp_q.push_back(6'h21);
        @(negedge clk);
        chk("bp_no_pop", arb_if.pop_vc0, 0);
        @(negedge clk);
        chk("bp_stall", arb_if.stall_out, 1);
        chk("bp_stall_no_pop", arb_if.pop_vc0, 0);
        tick();
        arb_if.d1_almost_full = 1'b0;
        @(negedge clk);
        chk("bp_release_no_pop", arb_if.pop_vc0, 0);
        @(negedge clk);
        chk("bp_run_pop", arb_if.pop_vc0, 1);
        chk("bp_run_stall", arb_if.stall_out, 0);
        @(negedge clk);
        chk("bp_push_d1", arb_if.push_d1, 1);

        // Mixed destinations: VC0 blocked on D1, VC1 goes to D0
        tick();
        arb_if.d1_almost_full = 1'b1;
        q0.push_back(6'h22);
        q1.push_back(6'h05);
        exp_q.push_back(6'h05);
        exp_q.push_back(6'h22);
        @(negedge clk);
        chk("mix_pop_vc1", arb_if.pop_vc1, 1);
        chk("mix_pop_vc0", arb_if.pop_vc0, 0);
        @(negedge clk);
        chk("mix_push_d0", arb_if.push_d0, 1);
        chk("mix_vc0_head", arb_if.vc0_data, 6'h22);
        chk("mix_pop_vc0_hold", arb_if.pop_vc0, 0);
        @(negedge clk);
        chk("mix_stall", arb_if.stall_out, 1);
        tick();
        arb_if.d1_almost_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mix_push_d1", arb_if.push_d1, 1);
        chk("mix_sent_d0", arb_if.sent_d0, 15);
        chk("mix_sent_d1", arb_if.sent_d1, 2);

        // Disruption: active drops in the push cycle
        tick();
        q0.push_back(6'h03);
        q0.push_back(6'h04);
        exp_q.push_back(6'h03);
        @(negedge clk);
        chk("dis_pop", arb_if.pop_vc0, 1);
        tick();
        arb_if.active = 1'b0;
        @(negedge clk);
        chk("dis_push_held", arb_if.push_d0, 1);
        chk("dis_no_pop", arb_if.pop_vc0, 0);
        @(negedge clk);
        chk("dis_idle", arb_if.idle_out, 1);
        chk("dis_push_done", arb_if.push_d0, 0);
        tick();
        arb_if.active = 1'b1;
        exp_q.push_back(6'h04);
        @(negedge clk);
        @(negedge clk);
        chk("dis_resume_pop", arb_if.pop_vc0, 1);
        @(negedge clk);
        chk("dis_resume_push", arb_if.push_d0, 1);
        chk("dis_sent_d0", arb_if.sent_d0, 17);

        // Reset right after a pop: the popped word is lost
        tick();
        q0.push_back(6'h07);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_pop", arb_if.pop_vc0, 1);
        tick();
        reset = 1'b0;
        arb_if.active = 1'b0;
        @(negedge clk);
        chk("rst_mid_push_d0", arb_if.push_d0, 0);
        chk("rst_mid_push_d1", arb_if.push_d1, 0);
        chk("rst_mid_sent_d0", arb_if.sent_d0, 0);
        chk("rst_mid_sent_d1", arb_if.sent_d1, 0);
        chk("rst_mid_idle", arb_if.idle_out, 1);
        chk("rst_mid_word_lost", arb_if.vc0_empty, 1);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
